// File: rtl/midi_pkg.sv
// Shared MIDI constants, stack command encoding and parser state type
// for the monophonic note controller.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] CTRL       = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;
    localparam logic [3:0] PITCH_BEND = 4'hE;

    localparam logic [13:0] PITCH_CENTER     = 14'h2000;
    localparam logic [6:0]  CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        NOP,
        PUSH,
        REMOVE,
        CLEAR
    } stack_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DATA1,
        DATA2
    } parse_state_e;

endpackage

// File: rtl/note_stack.sv
// Last-note-priority key stack: entry 0 is the oldest held key, entry count-1 the newest.
// Every operation finishes in one cycle by compare-and-shift across all entries.
module note_stack
    import midi_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  stack_op_e op,
    input  logic [6:0] key,
    input  logic [6:0] vel,
    output logic [6:0] top_key,
    output logic [6:0] top_vel,
    output logic       empty
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [6:0]    keys_q [STACK_DEPTH];
    logic [6:0]    keys_d [STACK_DEPTH];
    logic [6:0]    vels_q [STACK_DEPTH];
    logic [6:0]    vels_d [STACK_DEPTH];
    logic [6:0]    rem_keys [STACK_DEPTH];
    logic [6:0]    rem_vels [STACK_DEPTH];
    logic [CW-1:0] count_q, count_d, rem_count;
    logic [6:0]    top_key_q, top_key_d, top_vel_q, top_vel_d;
    logic          hit;

    // Removal of the matching key is shared by REMOVE and by PUSH of an already-held key.
    always_comb begin
        rem_keys = keys_q;
        rem_vels = vels_q;
        hit      = 1'b0;
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            if (CW'(i) < count_q && keys_q[i] == key) hit = 1'b1;
            if (hit) begin
                rem_keys[i] = keys_q[i+1];
                rem_vels[i] = vels_q[i+1];
            end
        end
        if (CW'(STACK_DEPTH - 1) < count_q && keys_q[STACK_DEPTH-1] == key) hit = 1'b1;
        rem_count = hit ? count_q - CW'(1) : count_q;
    end

    always_comb begin
        keys_d    = keys_q;
        vels_d    = vels_q;
        count_d   = count_q;
        top_key_d = top_key_q;
        top_vel_d = top_vel_q;
        case (op)
            PUSH: begin
                keys_d = rem_keys;
                vels_d = rem_vels;
                if (rem_count == CW'(STACK_DEPTH)) begin
                    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                        keys_d[i] = rem_keys[i+1];
                        vels_d[i] = rem_vels[i+1];
                    end
                    keys_d[STACK_DEPTH-1] = key;
                    vels_d[STACK_DEPTH-1] = vel;
                    count_d = CW'(STACK_DEPTH);
                end else begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (rem_count == CW'(i)) begin
                            keys_d[i] = key;
                            vels_d[i] = vel;
                        end
                    end
                    count_d = rem_count + CW'(1);
                end
            end
            REMOVE: begin
                keys_d  = rem_keys;
                vels_d  = rem_vels;
                count_d = rem_count;
            end
            CLEAR:   count_d = '0;
            default: ;
        endcase
        // An empty stack leaves the last top entry visible.
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (count_d == CW'(i + 1)) begin
                top_key_d = keys_d[i];
                top_vel_d = vels_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                keys_q[i] <= '0;
                vels_q[i] <= '0;
            end
            count_q   <= '0;
            top_key_q <= '0;
            top_vel_q <= '0;
        end else begin
            keys_q    <= keys_d;
            vels_q    <= vels_d;
            count_q   <= count_d;
            top_key_q <= top_key_d;
            top_vel_q <= top_vel_d;
        end
    end

    assign top_key = top_key_q;
    assign top_vel = top_vel_q;
    assign empty   = (count_q == '0);

endmodule

// File: rtl/midi_note_ctrl.sv
// Monophonic MIDI note controller: running-status parser, registered command
// decode, note stack and pitch-bend register, all on one channel.
module midi_note_ctrl
    import midi_pkg::*;
#(
    parameter int CHANNEL     = 0,
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_rdy,
    input  logic [7:0]  byte_data,
    output logic        gate,
    output logic [6:0]  note,
    output logic [6:0]  velocity,
    output logic [13:0] pitch
);

    parse_state_e state_q, state_d;
    logic [7:0]   status_q, status_d;
    logic [6:0]   d1_q, d1_d, d2_q, d2_d;
    logic         done_q, done_d;
    stack_op_e    op_q, op_d;
    logic [6:0]   key_q, key_d, vel_q, vel_d;
    logic         bend_q, bend_d;
    logic [13:0]  bend_val_q, bend_val_d, pitch_q;
    logic         empty;
    logic         one_byte_msg;

    assign one_byte_msg = (status_q[7:4] == PROG) || (status_q[7:4] == CHAN_PRESS);

    // Parser: realtime bytes are invisible, system common drops running status,
    // any channel status restarts a message.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        done_d   = 1'b0;
        if (byte_rdy) begin
            if (byte_data >= 8'hF8) begin
                state_d = state_q;
            end else if (byte_data >= 8'hF0) begin
                state_d  = IDLE;
                status_d = '0;
            end else if (byte_data[7]) begin
                state_d  = DATA1;
                status_d = byte_data;
            end else begin
                case (state_q)
                    DATA1: begin
                        d1_d = byte_data[6:0];
                        if (one_byte_msg) done_d = 1'b1;
                        else              state_d = DATA2;
                    end
                    DATA2: begin
                        d2_d    = byte_data[6:0];
                        done_d  = 1'b1;
                        state_d = DATA1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        op_d       = NOP;
        key_d      = d1_q;
        vel_d      = d2_q;
        bend_d     = 1'b0;
        bend_val_d = {d2_q, d1_q};
        if (done_q && status_q[3:0] == CHANNEL[3:0]) begin
            case (status_q[7:4])
                NOTE_ON:    op_d = (d2_q != '0) ? PUSH : REMOVE;
                NOTE_OFF:   op_d = REMOVE;
                CTRL:       if (d1_q == CC_ALL_NOTES_OFF) op_d = CLEAR;
                PITCH_BEND: bend_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            status_q   <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            done_q     <= 1'b0;
            op_q       <= NOP;
            key_q      <= '0;
            vel_q      <= '0;
            bend_q     <= 1'b0;
            bend_val_q <= PITCH_CENTER;
            pitch_q    <= PITCH_CENTER;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            done_q     <= done_d;
            op_q       <= op_d;
            key_q      <= key_d;
            vel_q      <= vel_d;
            bend_q     <= bend_d;
            bend_val_q <= bend_val_d;
            if (bend_q) pitch_q <= bend_val_q;
        end
    end

    note_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .op      (op_q),
        .key     (key_q),
        .vel     (vel_q),
        .top_key (note),
        .top_vel (velocity),
        .empty   (empty)
    );

    assign gate  = ~empty;
    assign pitch = pitch_q;

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Scoreboarded bench for midi_note_ctrl: a byte-level reference model queues the
// expected outputs per completed message; a monitor retires them on their due cycle.
module tb_midi_note_ctrl;

    localparam int CH    = 0;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic        gate;
        logic [6:0]  note;
        logic [6:0]  vel;
        logic [13:0] pitch;
    } outs_t;

    typedef struct packed {
        int    due;
        outs_t exp;
    } sb_t;

    typedef struct packed {
        logic [6:0] key;
        logic [6:0] vel;
    } entry_t;

    localparam outs_t RESET_OUTS = '{gate: 1'b0, note: 7'd0, vel: 7'd0, pitch: 14'h2000};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_rdy = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        gate;
    logic [6:0]  note, velocity;
    logic [13:0] pitch;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    sb_t    sb[$];
    outs_t  curExp;

    // Reference model state
    int         runStatus;
    logic [6:0] pend[$];
    entry_t     stk[$];
    logic [6:0] lastNote, lastVel;
    logic [13:0] pitchM;

    midi_note_ctrl #(
        .CHANNEL     (CH),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_rdy  (byte_rdy),
        .byte_data (byte_data),
        .gate      (gate),
        .note      (note),
        .velocity  (velocity),
        .pitch     (pitch)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic modelReset();
        runStatus = -1;
        pend.delete();
        stk.delete();
        lastNote = '0;
        lastVel  = '0;
        pitchM   = 14'h2000;
    endtask

    task automatic stackRemove(input logic [6:0] k);
        for (int i = 0; i < stk.size(); i++) begin
            if (stk[i].key == k) begin
                stk.delete(i);
                break;
            end
        end
    endtask

    task automatic applyMessage(input logic [3:0] typ, input logic [3:0] chan,
                                input logic [6:0] d1, input logic [6:0] d2);
        entry_t e;
        if (chan != CH[3:0]) return;
        case (typ)
            4'h9: begin
                if (d2 != 0) begin
                    stackRemove(d1);
                    if (stk.size() == DEPTH) stk.delete(0);
                    e.key = d1;
                    e.vel = d2;
                    stk.push_back(e);
                end else begin
                    stackRemove(d1);
                end
            end
            4'h8: stackRemove(d1);
            4'hB: if (d1 == 7'd123) stk.delete();
            4'hE: pitchM = {d2, d1};
            default: ;
        endcase
        if (stk.size() > 0) begin
            lastNote = stk[stk.size()-1].key;
            lastVel  = stk[stk.size()-1].vel;
        end
    endtask

    task automatic modelByte(input logic [7:0] b, input int edgeIdx);
        logic [7:0] st;
        int need;
        sb_t s;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            runStatus = -1;
            pend.delete();
            return;
        end
        if (b[7]) begin
            runStatus = int'(b);
            pend.delete();
            return;
        end
        if (runStatus < 0) return;
        pend.push_back(b[6:0]);
        st = runStatus[7:0];
        need = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 1 : 2;
        if (pend.size() == need) begin
            applyMessage(st[7:4], st[3:0], pend[0], (need == 2) ? pend[1] : 7'd0);
            pend.delete();
            s.due       = edgeIdx + 2;
            s.exp.gate  = (stk.size() > 0);
            s.exp.note  = lastNote;
            s.exp.vel   = lastVel;
            s.exp.pitch = pitchM;
            sb.push_back(s);
        end
    endtask

    // Driver tasks are entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        byte_rdy  = 1'b1;
        byte_data = b;
        @(posedge clk);
        #1;
        byte_rdy = 1'b0;
        modelByte(b, cyc);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        sb.delete();
        modelReset();
        idleCycles(2);
        rst = 1'b0;
    endtask

    task automatic sendMsg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
    endtask

    task automatic checkOutput();
        outs_t got;
        got = '{gate: gate, note: note, vel: velocity, pitch: pitch};
        checks++;
        if (got !== curExp) begin
            errors++;
            if (errors <= 20)
                $display("[TB] FAIL outputs cycle=%0d got gate=%0b note=%0d vel=%0d pitch=%h, need gate=%0b note=%0d vel=%0d pitch=%h",
                         cyc, got.gate, got.note, got.vel, got.pitch,
                         curExp.gate, curExp.note, curExp.vel, curExp.pitch);
        end
    endtask

    // Monitor: retire the expectation whose due cycle has arrived, then compare.
    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                curExp = RESET_OUTS;
            end else begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_late due=%0d now=%0d", sb[0].due, cyc);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].due == cyc) curExp = sb.pop_front().exp;
            end
            checkOutput();
        end
    end

    initial begin
        int r;
        curExp = RESET_OUTS;
        modelReset();
        #2;
        rst = 1'b1;
        started = 1'b1;
        idleCycles(3);
        rst = 1'b0;
        idleCycles(2);

        // Basic note on, legato with running status, note-on-zero release
        sendMsg(8'h90, 8'h3C, 8'h64);
        idleCycles(3);
        sendMsg(8'h90, 8'h3C, 8'h40);
        applyStimulus(8'h40);
        applyStimulus(8'h50);
        sendMsg(8'h80, 8'h40, 8'h00);
        sendMsg(8'h90, 8'h3C, 8'h00);
        idleCycles(3);

        // Overflow: keys 1..9 then release 9..1
        for (int k = 1; k <= 9; k++) sendMsg(8'h90, 8'(k), 8'h64);
        for (int k = 9; k >= 1; k--) begin
            sendMsg(8'h80, 8'(k), 8'h00);
            idleCycles(1);
        end

        // Pitch bend, with a realtime byte between the data bytes
        sendMsg(8'hE0, 8'h7F, 8'h7F);
        idleCycles(2);
        applyStimulus(8'hE0);
        applyStimulus(8'h10);
        applyStimulus(8'hF8);
        applyStimulus(8'h55);
        sendMsg(8'h90, 8'h30, 8'h22);
        sendMsg(8'h90, 8'h31, 8'h23);
        sendMsg(8'hB0, 8'h7B, 8'h00);
        idleCycles(3);

        // Channel filter and aborted message
        sendMsg(8'h91, 8'h3C, 8'h64);
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        applyStimulus(8'hF2);
        applyStimulus(8'h64);
        idleCycles(3);

        // Reset between d1 and d2, then a stray data byte
        sendMsg(8'h90, 8'h45, 8'h11);
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        doReset();
        applyStimulus(8'h64);
        applyStimulus(8'h22);
        idleCycles(3);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                if ($urandom_range(0, 1) == 1) applyStimulus(8'h90);
                applyStimulus(8'($urandom_range(60, 71)));
                applyStimulus(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127)));
            end else if (r < 55) begin
                sendMsg(8'h80, 8'($urandom_range(60, 71)), 8'($urandom_range(0, 127)));
            end else if (r < 62) begin
                sendMsg(8'hE0, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)));
            end else if (r < 65) begin
                sendMsg(8'hB0, ($urandom_range(0, 1) == 1) ? 8'h7B : 8'($urandom_range(0, 127)), 8'h00);
            end else if (r < 72) begin
                sendMsg({1'b1, 3'($urandom_range(0, 6)), 4'($urandom_range(1, 15))},
                        8'($urandom_range(60, 71)), 8'($urandom_range(0, 127)));
            end else if (r < 78) begin
                applyStimulus(8'($urandom_range(8'hF8, 8'hFF)));
            end else if (r < 81) begin
                applyStimulus(8'($urandom_range(8'hF0, 8'hF7)));
            end else if (r < 90) begin
                applyStimulus(8'($urandom_range(0, 127)));
            end else if (r < 95) begin
                applyStimulus(($urandom_range(0, 1) == 1) ? 8'hC0 : 8'hD0);
                applyStimulus(8'($urandom_range(0, 127)));
            end else if (r < 99) begin
                idleCycles($urandom_range(0, 3));
            end else begin
                doReset();
            end
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) idleCycles(1);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain left=%0d need=0", sb.size());
        end
        idleCycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
